// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ctrl_pipe_pkg
// Purpose  : Shared types and constants for the control-word pipeline.
//            - ctrl_t      : decoded control word carried through EX/MEM/WB
//            - CTRL_BUBBLE : all-zero control word used for inserted bubbles
//            - REG_AW_DEF  : default register index width
//            - OP_*        : primary opcodes understood by the decoder
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pipe_pkg;

  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage
`default_nettype wire

// File: rtl/ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_hazard_detect
// Purpose  : Combinational hazard and control-transfer resolution for the
//            instruction in EX against the instruction waiting in ID.
// Ports    :
//   ex_valid_i      EX stage holds a real instruction
//   ex_mem_read_i   EX instruction is a load
//   ex_branch_eq_i  EX instruction is beq
//   ex_branch_ne_i  EX instruction is bne
//   ex_jump_i       EX instruction is a jump
//   ex_rt_i         EX instruction rt field (load destination)
//   ex_zero_i       ALU zero flag for the EX instruction
//   id_valid_i      ID stage holds a real instruction
//   id_rs_i/id_rt_i ID instruction source register fields
//   load_use_o      ID instruction needs the load result currently in EX
//   branch_taken_o  conditional branch in EX is taken
//   jump_taken_o    jump in EX
//   flush_o         squash the ID instruction (taken branch or jump)
// Revision : 1.0  initial release
// ============================================================================
module ctrl_hazard_detect
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_branch_eq_i,
  input  logic              ex_branch_ne_i,
  input  logic              ex_jump_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              ex_zero_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              load_use_o,
  output logic              branch_taken_o,
  output logic              jump_taken_o,
  output logic              flush_o
);

  logic w_rt_match;

  // Register 0 is hardwired, so a load into r0 never creates a dependency.
  assign w_rt_match     = (ex_rt_i != '0) &&
                          ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  assign load_use_o     = ex_valid_i & ex_mem_read_i & id_valid_i & w_rt_match;

  assign branch_taken_o = ex_valid_i & ((ex_branch_eq_i &  ex_zero_i) |
                                        (ex_branch_ne_i & ~ex_zero_i));
  assign jump_taken_o   = ex_valid_i & ex_jump_i;
  assign flush_o        = branch_taken_o | jump_taken_o;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Carries decoded control bits and register indices through the
//            ID/EX, EX/MEM and MEM/WB pipeline registers, inserts bubbles on
//            load-use hazards and on taken branches/jumps, and counts them.
// Ports    :
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_*                       decoded control word and register fields in ID
//   ex_zero                    ALU zero flag for the instruction in EX
//   hold_if_id                 freeze PC and IF/ID this cycle (combinational)
//   pc_src_branch/pc_src_jump  redirect PC (combinational)
//   ex_*, mem_*, wb_*          per-stage controls, zero when stage invalid
//   bubble_cnt                 saturating count of inserted bubbles
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_branch_eq,
  input  logic              id_branch_ne,
  input  logic              id_jump,
  input  logic [1:0]        id_alu_op,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_alu_src,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              hold_if_id,
  output logic              pc_src_branch,
  output logic              pc_src_jump,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [REG_AW-1:0] mem_dest,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dest,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ID/EX
  logic              idex_valid_q, idex_valid_d;
  ctrl_t             idex_ctrl_q,  idex_ctrl_d;
  logic [REG_AW-1:0] idex_rt_q,    idex_rt_d;
  logic [REG_AW-1:0] idex_rd_q,    idex_rd_d;
  // EX/MEM
  logic              exmem_valid_q;
  logic              exmem_mem_read_q;
  logic              exmem_mem_write_q;
  logic              exmem_mem_to_reg_q;
  logic              exmem_reg_write_q;
  logic [REG_AW-1:0] exmem_dest_q, exmem_dest_d;
  // MEM/WB
  logic              memwb_valid_q;
  logic              memwb_mem_to_reg_q;
  logic              memwb_reg_write_q;
  logic [REG_AW-1:0] memwb_dest_q, memwb_dest_d;
  // Event counter
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  ctrl_t             w_id_ctrl;
  logic [REG_AW-1:0] w_ex_dest;
  logic              w_load_use;
  logic              w_branch_taken;
  logic              w_jump_taken;
  logic              w_flush;
  logic              w_count_evt;

  assign w_id_ctrl = '{
    branch_eq:  id_branch_eq,
    branch_ne:  id_branch_ne,
    jump:       id_jump,
    alu_op:     id_alu_op,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    reg_dst:    id_reg_dst,
    reg_write:  id_reg_write,
    alu_src:    id_alu_src
  };

  ctrl_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid_i     (idex_valid_q),
    .ex_mem_read_i  (idex_ctrl_q.mem_read),
    .ex_branch_eq_i (idex_ctrl_q.branch_eq),
    .ex_branch_ne_i (idex_ctrl_q.branch_ne),
    .ex_jump_i      (idex_ctrl_q.jump),
    .ex_rt_i        (idex_rt_q),
    .ex_zero_i      (ex_zero),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .load_use_o     (w_load_use),
    .branch_taken_o (w_branch_taken),
    .jump_taken_o   (w_jump_taken),
    .flush_o        (w_flush)
  );

  // A flush takes priority: the ID word is wrong-path, so it must not be held.
  assign hold_if_id    = w_load_use & ~w_flush;
  assign pc_src_branch = w_branch_taken;
  assign pc_src_jump   = w_jump_taken;

  // ID/EX next state. Register fields only move with a real instruction so
  // that an invalid stage keeps showing the last indices it carried.
  always_comb begin
    idex_valid_d = id_valid;
    idex_ctrl_d  = w_id_ctrl;
    idex_rt_d    = idex_rt_q;
    idex_rd_d    = idex_rd_q;
    if (w_flush || w_load_use) begin
      idex_valid_d = 1'b0;
      idex_ctrl_d  = CTRL_BUBBLE;
    end else if (id_valid) begin
      idex_rt_d = id_rt;
      idex_rd_d = id_rd;
    end
  end

  assign w_ex_dest    = idex_ctrl_q.reg_dst ? idex_rd_q : idex_rt_q;
  assign exmem_dest_d = idex_valid_q  ? w_ex_dest    : exmem_dest_q;
  assign memwb_dest_d = exmem_valid_q ? exmem_dest_q : memwb_dest_q;

  // load_use already implies id_valid; a cycle with both causes counts once.
  assign w_count_evt = w_load_use | (w_flush & id_valid);

  always_comb begin
    cnt_d = cnt_q;
    if (w_count_evt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_q       <= 1'b0;
      idex_ctrl_q        <= CTRL_BUBBLE;
      idex_rt_q          <= '0;
      idex_rd_q          <= '0;
      exmem_valid_q      <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_dest_q       <= '0;
      memwb_valid_q      <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_dest_q       <= '0;
      cnt_q              <= '0;
    end else begin
      idex_valid_q       <= idex_valid_d;
      idex_ctrl_q        <= idex_ctrl_d;
      idex_rt_q          <= idex_rt_d;
      idex_rd_q          <= idex_rd_d;
      exmem_valid_q      <= idex_valid_q;
      exmem_mem_read_q   <= idex_ctrl_q.mem_read;
      exmem_mem_write_q  <= idex_ctrl_q.mem_write;
      exmem_mem_to_reg_q <= idex_ctrl_q.mem_to_reg;
      exmem_reg_write_q  <= idex_ctrl_q.reg_write;
      exmem_dest_q       <= exmem_dest_d;
      memwb_valid_q      <= exmem_valid_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_dest_q       <= memwb_dest_d;
      cnt_q              <= cnt_d;
    end
  end

  // Stage outputs are qualified by the stage valid bit.
  assign ex_alu_op     = idex_valid_q ? idex_ctrl_q.alu_op : 2'b00;
  assign ex_alu_src    = idex_valid_q & idex_ctrl_q.alu_src;
  assign ex_reg_dst    = idex_valid_q & idex_ctrl_q.reg_dst;
  assign ex_rt         = idex_rt_q;
  assign ex_rd         = idex_rd_q;

  assign mem_mem_read  = exmem_valid_q & exmem_mem_read_q;
  assign mem_mem_write = exmem_valid_q & exmem_mem_write_q;
  assign mem_dest      = exmem_dest_q;

  // r0 is never written.
  assign wb_reg_write  = memwb_valid_q & memwb_reg_write_q & (memwb_dest_q != '0);
  assign wb_mem_to_reg = memwb_valid_q & memwb_mem_to_reg_q;
  assign wb_dest       = memwb_dest_q;

  assign bubble_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Self-checking bench for ctrl_pipe: directed vector table,
//            hand-written corner sequences and randomized instruction stream
//            checked against an instruction-level pipeline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  typedef struct packed {
    logic       v;
    logic       beq;
    logic       bne;
    logic       j;
    logic [1:0] aop;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asrc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } word_t;

  typedef struct {
    word_t      w;
    logic       z;
    logic       hold;
    logic       pcb;
    logic       pcj;
    logic       ex_rdst;
    logic [4:0] ex_rd;
    logic       mem_rd;
    logic       mem_wr;
    logic       wb_rw;
    logic [4:0] wb_dest;
    int         cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_branch_eq, id_branch_ne, id_jump;
  logic [1:0] id_alu_op;
  logic       id_mem_read, id_mem_write, id_mem_to_reg, id_reg_dst, id_reg_write, id_alu_src;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;

  logic        hold_if_id, pc_src_branch, pc_src_jump;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_dst;
  logic [4:0]  ex_rt, ex_rd;
  logic        mem_mem_read, mem_mem_write;
  logic [4:0]  mem_dest;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_dest;
  logic [15:0] bubble_cnt;

  logic        d2_hold_if_id, d2_pc_src_branch, d2_pc_src_jump;
  logic [1:0]  d2_ex_alu_op;
  logic        d2_ex_alu_src, d2_ex_reg_dst;
  logic [4:0]  d2_ex_rt, d2_ex_rd;
  logic        d2_mem_mem_read, d2_mem_mem_write;
  logic [4:0]  d2_mem_dest;
  logic        d2_wb_reg_write, d2_wb_mem_to_reg;
  logic [4:0]  d2_wb_dest;
  logic [1:0]  d2_bubble_cnt;

  ctrl_pipe #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_branch_eq(id_branch_eq), .id_branch_ne(id_branch_ne), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .hold_if_id(hold_if_id), .pc_src_branch(pc_src_branch), .pc_src_jump(pc_src_jump),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_dest(mem_dest), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest(wb_dest), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  ctrl_pipe #(.REG_AW(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_branch_eq(id_branch_eq), .id_branch_ne(id_branch_ne), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .hold_if_id(d2_hold_if_id), .pc_src_branch(d2_pc_src_branch), .pc_src_jump(d2_pc_src_jump),
    .ex_alu_op(d2_ex_alu_op), .ex_alu_src(d2_ex_alu_src), .ex_reg_dst(d2_ex_reg_dst),
    .ex_rt(d2_ex_rt), .ex_rd(d2_ex_rd), .mem_mem_read(d2_mem_mem_read),
    .mem_mem_write(d2_mem_mem_write), .mem_dest(d2_mem_dest), .wb_reg_write(d2_wb_reg_write),
    .wb_mem_to_reg(d2_wb_mem_to_reg), .wb_dest(d2_wb_dest), .bubble_cnt(d2_bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- decoder
  function automatic word_t mk(input logic [5:0] op, input int rs, input int rt, input int rd);
    word_t w;
    w    = '0;
    w.v  = 1'b1;
    w.rs = 5'(rs);
    w.rt = 5'(rt);
    w.rd = 5'(rd);
    case (op)
      OP_RTYPE: begin w.aop = 2'b10; w.rdst = 1'b1; w.rw = 1'b1; end
      OP_LW:    begin w.mr = 1'b1; w.m2r = 1'b1; w.rw = 1'b1; w.asrc = 1'b1; end
      OP_SW:    begin w.mw = 1'b1; w.asrc = 1'b1; end
      OP_BEQ:   begin w.beq = 1'b1; w.aop = 2'b01; end
      OP_BNE:   begin w.bne = 1'b1; w.aop = 2'b01; end
      OP_J:     begin w.j = 1'b1; end
      OP_ADDI:  begin w.rw = 1'b1; w.asrc = 1'b1; end
      default:  begin end
    endcase
    return w;
  endfunction

  function automatic logic [4:0] dest_of(input word_t w);
    return w.rdst ? w.rd : w.rt;
  endfunction

  // ------------------------------------------------------- reference model
  // pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB.
  word_t pipe[$];
  int    m_cnt;
  word_t cur_w;
  logic  cur_z;
  logic  m_lu, m_br, m_jp, m_hold;

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back('0);
    m_cnt = 0;
  endtask

  task automatic model_comb();
    word_t e;
    e      = pipe[0];
    m_lu   = e.v && e.mr && (e.rt != 0) && cur_w.v && (e.rt == cur_w.rs || e.rt == cur_w.rt);
    m_br   = e.v && ((e.beq && cur_z) || (e.bne && !cur_z));
    m_jp   = e.v && e.j;
    m_hold = m_lu && !(m_br || m_jp);
  endtask

  task automatic model_step();
    word_t n;
    n = (m_lu || m_br || m_jp) ? word_t'('0) : cur_w;
    pipe.push_front(n);
    void'(pipe.pop_back());
    if ((m_lu || ((m_br || m_jp) && cur_w.v)) && m_cnt < 65535) m_cnt++;
  endtask

  task automatic model_check();
    word_t e, m, w;
    model_comb();
    e = pipe[0]; m = pipe[1]; w = pipe[2];
    chk("hold_if_id",    hold_if_id,    m_hold);
    chk("pc_src_branch", pc_src_branch, m_br);
    chk("pc_src_jump",   pc_src_jump,   m_jp);
    chk("ex_alu_op",     ex_alu_op,     e.v ? e.aop : 2'b00);
    chk("ex_alu_src",    ex_alu_src,    e.v && e.asrc);
    chk("ex_reg_dst",    ex_reg_dst,    e.v && e.rdst);
    if (e.v) begin
      chk("ex_rt", ex_rt, e.rt);
      chk("ex_rd", ex_rd, e.rd);
    end
    chk("mem_mem_read",  mem_mem_read,  m.v && m.mr);
    chk("mem_mem_write", mem_mem_write, m.v && m.mw);
    if (m.v) chk("mem_dest", mem_dest, dest_of(m));
    chk("wb_reg_write",  wb_reg_write,  w.v && w.rw && (dest_of(w) != 5'd0));
    chk("wb_mem_to_reg", wb_mem_to_reg, w.v && w.m2r);
    if (w.v) chk("wb_dest", wb_dest, dest_of(w));
    chk("bubble_cnt",    bubble_cnt,    m_cnt);
    chk("bubble_cnt_w2", d2_bubble_cnt, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  // ------------------------------------------------------------- drivers
  task automatic drive(input word_t w, input logic z);
    cur_w = w; cur_z = z;
    id_valid = w.v; id_branch_eq = w.beq; id_branch_ne = w.bne; id_jump = w.j;
    id_alu_op = w.aop; id_mem_read = w.mr; id_mem_write = w.mw; id_mem_to_reg = w.m2r;
    id_reg_dst = w.rdst; id_reg_write = w.rw; id_alu_src = w.asrc;
    id_rs = w.rs; id_rt = w.rt; id_rd = w.rd; ex_zero = z;
  endtask

  // Drive after the rising edge, check at the falling edge.
  task automatic apply(input word_t w, input logic z);
    drive(w, z);
    @(negedge clk);
    model_check();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic vec_t mkv(input word_t w, input logic z, input logic hold, input logic pcb,
                               input logic pcj, input logic rdst, input int exrd, input logic mrd,
                               input logic mwr, input logic wrw, input int wdest, input int cnt);
    vec_t v;
    v.w = w; v.z = z; v.hold = hold; v.pcb = pcb; v.pcj = pcj; v.ex_rdst = rdst;
    v.ex_rd = 5'(exrd); v.mem_rd = mrd; v.mem_wr = mwr; v.wb_rw = wrw;
    v.wb_dest = 5'(wdest); v.cnt = cnt;
    return v;
  endfunction

  function automatic int rreg();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  vec_t       tbl[14];
  word_t      nop;
  word_t      w_r, w_lwb;
  logic [5:0] ops[7];

  initial begin
    nop = '0;
    ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    rst_n = 1'b0;
    drive(nop, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- directed table: add, lw-use stall, beq taken/not taken
    //                 w                        z  hold pcb pcj rdst exrd mrd mwr wrw wdst cnt
    tbl[0]  = mkv(mk(OP_RTYPE, 1, 2, 5), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(nop,                    0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(nop,                    0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(nop,                    0, 0, 0, 0, 0, 5, 0, 0, 1, 5, 0);
    tbl[4]  = mkv(mk(OP_LW, 0, 8, 0),     0, 0, 0, 0, 0, 5, 0, 0, 0, 5, 0);
    tbl[5]  = mkv(mk(OP_RTYPE, 8, 3, 9),  0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    tbl[6]  = mkv(mk(OP_RTYPE, 8, 3, 9),  0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 1);
    tbl[7]  = mkv(nop,                    0, 0, 0, 0, 1, 9, 0, 0, 1, 8, 1);
    tbl[8]  = mkv(mk(OP_BEQ, 1, 2, 0),    0, 0, 0, 0, 0, 9, 0, 0, 0, 8, 1);
    tbl[9]  = mkv(mk(OP_RTYPE, 1, 2, 7),  1, 0, 1, 0, 0, 0, 0, 0, 1, 9, 1);
    tbl[10] = mkv(nop,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2);
    tbl[11] = mkv(mk(OP_BEQ, 1, 2, 0),    0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    tbl[12] = mkv(mk(OP_ADDI, 1, 4, 0),   0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    tbl[13] = mkv(nop,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].w, tbl[i].z);
      chk($sformatf("tbl%0d_hold", i),    hold_if_id,    tbl[i].hold);
      chk($sformatf("tbl%0d_pcb", i),     pc_src_branch, tbl[i].pcb);
      chk($sformatf("tbl%0d_pcj", i),     pc_src_jump,   tbl[i].pcj);
      chk($sformatf("tbl%0d_exrdst", i),  ex_reg_dst,    tbl[i].ex_rdst);
      chk($sformatf("tbl%0d_exrd", i),    ex_rd,         tbl[i].ex_rd);
      chk($sformatf("tbl%0d_memrd", i),   mem_mem_read,  tbl[i].mem_rd);
      chk($sformatf("tbl%0d_memwr", i),   mem_mem_write, tbl[i].mem_wr);
      chk($sformatf("tbl%0d_wbrw", i),    wb_reg_write,  tbl[i].wb_rw);
      chk($sformatf("tbl%0d_wbdest", i),  wb_dest,       tbl[i].wb_dest);
      chk($sformatf("tbl%0d_cnt", i),     bubble_cnt,    tbl[i].cnt);
      step();
    end

    // ---------------- bne taken, then jump
    apply(mk(OP_BNE, 1, 2, 0), 1'b0); step();
    apply(mk(OP_RTYPE, 1, 2, 6), 1'b0);
    chk("bne_taken", pc_src_branch, 1'b1);
    step();
    apply(mk(OP_J, 0, 0, 0), 1'b0); step();
    apply(mk(OP_RTYPE, 3, 3, 7), 1'b1);
    chk("jump_pcj", pc_src_jump, 1'b1);
    chk("jump_pcb", pc_src_branch, 1'b0);
    step();
    apply(nop, 1'b0);
    chk("jump_squash_ex", ex_reg_dst, 1'b0);
    chk("cnt_after_bne_j", bubble_cnt, 16'd4);
    step();

    // ---------------- load-use and taken branch in the same cycle
    w_lwb     = mk(OP_LW, 0, 8, 0);
    w_lwb.beq = 1'b1;
    apply(w_lwb, 1'b0); step();
    apply(mk(OP_RTYPE, 8, 1, 9), 1'b1);
    chk("lu_flush_hold", hold_if_id, 1'b0);
    chk("lu_flush_pcb", pc_src_branch, 1'b1);
    step();
    apply(nop, 1'b0);
    chk("lu_flush_cnt", bubble_cnt, 16'd5);
    step();

    // ---------------- write to r0 suppressed; store
    apply(mk(OP_RTYPE, 1, 2, 0), 1'b0); step();
    apply(mk(OP_SW, 1, 2, 0), 1'b0); step();
    apply(nop, 1'b0); step();
    apply(nop, 1'b0);
    chk("r0_wb_reg_write", wb_reg_write, 1'b0);
    chk("sw_mem_write", mem_mem_write, 1'b1);
    step();
    apply(nop, 1'b0);
    chk("sw_wb_reg_write", wb_reg_write, 1'b0);
    step();

    // ---------------- asynchronous reset with three instructions in flight
    apply(mk(OP_RTYPE, 1, 2, 3), 1'b0); step();
    apply(mk(OP_ADDI, 1, 4, 0), 1'b0); step();
    apply(mk(OP_LW, 0, 5, 0), 1'b0); step();
    drive(nop, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ex_alu_op", ex_alu_op, 2'b00);
    chk("rst_ex_alu_src", ex_alu_src, 1'b0);
    chk("rst_ex_rt", ex_rt, 5'd0);
    chk("rst_mem_read", mem_mem_read, 1'b0);
    chk("rst_mem_dest", mem_dest, 5'd0);
    chk("rst_wb_reg_write", wb_reg_write, 1'b0);
    chk("rst_wb_m2r", wb_mem_to_reg, 1'b0);
    chk("rst_wb_dest", wb_dest, 5'd0);
    chk("rst_cnt", bubble_cnt, 16'd0);
    chk("rst_cnt_w2", d2_bubble_cnt, 2'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      apply(nop, 1'b0);
      chk("post_rst_wb_reg_write", wb_reg_write, 1'b0);
      step();
    end

    // ---------------- five load-use bubbles: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      apply(mk(OP_LW, 0, 8, 0), 1'b0); step();
      apply(mk(OP_RTYPE, 8, 1, 9), 1'b0);
      chk("sat_hold", hold_if_id, 1'b1);
      step();
      apply(mk(OP_RTYPE, 8, 1, 9), 1'b0); step();
    end
    apply(nop, 1'b0);
    chk("sat_cnt16", bubble_cnt, 16'd5);
    chk("sat_cnt2", d2_bubble_cnt, 2'd3);
    step();

    // ---------------- randomized stream; upstream re-presents held words
    w_r = nop;
    m_hold = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!m_hold) begin
        w_r = mk(ops[$urandom_range(0, 6)], rreg(), rreg(), rreg());
        if ($urandom_range(0, 9) < 2) w_r.v = 1'b0;
      end
      apply(w_r, 1'($urandom_range(0, 1)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
